// File: rtl/double_minmax.sv
// Handshaked IEEE-754 double max/min (MODE=1 max, MODE=0 min), result always a bit copy of A or B.
// Optional macro DOUBLE_MINMAX_NAN_EN: any NaN operand yields the canonical quiet NaN.
module double_minmax #(
  parameter int MODE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [63:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  // state   | meaning
  // GET_A   | input_a_ack high, waiting for operand A
  // GET_B   | input_b_ack high, waiting for operand B
  // COMPARE | one cycle, result loaded into output_z
  // PUT_Z   | output_z_stb high until consumer acks
  typedef enum logic [1:0] {GET_A, GET_B, COMPARE, PUT_Z} state_t;

  generate
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("double_minmax: MODE must be 0 or 1");
    end
  endgenerate

  state_t      state, state_nxt;
  logic [63:0] a, a_nxt, b, b_nxt, z_nxt;
  logic        a_ack_nxt, b_ack_nxt, z_stb_nxt;
  logic        a_gt, b_gt;
  logic [63:0] result;

  // Sign-magnitude ordering; +0/-0 fall out of the sign rule, equal values keep A.
  always_comb begin
    a_gt = 1'b0;
    b_gt = 1'b0;
    if (a[63] != b[63]) begin
      a_gt = ~a[63];
      b_gt = a[63];
    end else if (!a[63]) begin
      a_gt = a[62:0] > b[62:0];
      b_gt = b[62:0] > a[62:0];
    end else begin
      a_gt = a[62:0] < b[62:0];
      b_gt = b[62:0] < a[62:0];
    end
    if (MODE == 1) result = b_gt ? b : a;
    else           result = a_gt ? b : a;
`ifdef DOUBLE_MINMAX_NAN_EN
    if ((a[62:52] == 11'h7FF && a[51:0] != 52'd0) ||
        (b[62:52] == 11'h7FF && b[51:0] != 52'd0))
      result = 64'h7FF8000000000000;
`endif
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    z_nxt     = output_z;
    a_ack_nxt = 1'b0;
    b_ack_nxt = 1'b0;
    z_stb_nxt = 1'b0;
    case (state)
      GET_A: begin
        a_ack_nxt = 1'b1;
        if (input_a_ack && input_a_stb) begin
          a_nxt     = input_a;
          a_ack_nxt = 1'b0;
          b_ack_nxt = 1'b1;
          state_nxt = GET_B;
        end
      end
      GET_B: begin
        b_ack_nxt = 1'b1;
        if (input_b_ack && input_b_stb) begin
          b_nxt     = input_b;
          b_ack_nxt = 1'b0;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        z_nxt     = result;
        z_stb_nxt = 1'b1;
        state_nxt = PUT_Z;
      end
      PUT_Z: begin
        z_stb_nxt = 1'b1;
        if (output_z_stb && output_z_ack) begin
          z_stb_nxt = 1'b0;
          a_ack_nxt = 1'b1;
          state_nxt = GET_A;
        end
      end
      default: state_nxt = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= GET_A;
      a            <= 64'h0;
      b            <= 64'h0;
      output_z     <= 64'h0;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      state        <= state_nxt;
      a            <= a_nxt;
      b            <= b_nxt;
      output_z     <= z_nxt;
      input_a_ack  <= a_ack_nxt;
      input_b_ack  <= b_ack_nxt;
      output_z_stb <= z_stb_nxt;
    end
  end

endmodule

// File: doc/double_minmax.md
DOUBLE_MINMAX -- requirements
Module: double_minmax

Interface
REQ-001 Parameter MODE, default 1, result select: 1 = maximum, 0 = minimum; any other value is illegal.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 input_a  input  64  operand A, IEEE-754 double bit pattern.
REQ-005 input_a_stb  input  1  producer asserts when input_a valid; holds until acked.
REQ-006 input_a_ack  output  1  responder ready for A; registered.
REQ-007 input_b  input  64  operand B, IEEE-754 double bit pattern.
REQ-008 input_b_stb  input  1  producer asserts when input_b valid; holds until acked.
REQ-009 input_b_ack  output  1  responder ready for B; registered.
REQ-010 output_z  output  64  result, IEEE-754 double bit pattern; registered.
REQ-011 output_z_stb  output  1  output_z valid; registered.
REQ-012 output_z_ack  input  1  consumer accepts output_z.

Function
REQ-013 FSM states: GET_A, GET_B, COMPARE, PUT_Z; at most one of input_a_ack, input_b_ack, output_z_stb high in any cycle.
REQ-014 GET_A: input_a_ack high; on an edge sampling input_a_stb=1 and input_a_ack=1, A is captured, input_a_ack drops, state moves to GET_B.
REQ-015 GET_B: input_b_ack high; on an edge sampling input_b_stb=1 and input_b_ack=1, B is captured, input_b_ack drops, state moves to COMPARE.
REQ-016 Strobes arriving in the wrong state (e.g. input_b_stb during GET_A) are ignored; no ack, no capture.
REQ-017 COMPARE lasts exactly one cycle; output_z loaded and output_z_stb asserted on the next edge, state moves to PUT_Z.
REQ-018 Latency: output_z_stb visible one cycle after the B handshake edge.
REQ-019 PUT_Z: output_z and output_z_stb held stable until an edge samples output_z_ack=1; on that edge output_z_stb drops and state moves to GET_A (input_a_ack high next cycle).
REQ-020 Unbounded backpressure on output_z_ack; no new operand is acked while in PUT_Z.
REQ-021 Ordering is sign-magnitude: positive > negative; both positive, larger magnitude greater; both negative, smaller magnitude greater.
REQ-022 +0 and -0 compare equal in value; MODE=1 returns +0 (64'h0000000000000000), MODE=0 returns -0 (64'h8000000000000000).
REQ-023 Otherwise-equal operands return A unchanged.
REQ-024 Infinities ordered as ordinary values (+inf greatest, -inf least); denormals ordered by magnitude.
REQ-025 output_z is always a bit-exact copy of A or B, except per REQ-029.

Reset
REQ-026 rst high at a rising edge: state GET_A, input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=64'h0, captured A/B cleared.
REQ-027 input_a_ack rises on the first rising edge sampling rst=0.
REQ-028 rst in any state aborts the operation; pending result discarded, output_z_stb low after that edge, no partial handshake completes.

Configuration
REQ-029 Macro DOUBLE_MINMAX_NAN_EN defined: if either operand is NaN (exponent all ones, mantissa nonzero), output_z = 64'h7FF8000000000000 (canonical quiet NaN), latency unchanged.
REQ-030 Macro undefined: no NaN detection; NaNs ordered by REQ-021 bit rules (positive NaN exceeds +inf).

Verification
REQ-031 MODE=1, A=64'h3FF3AE147AE147AE (1.23), B=64'h40123D70A3D70A3D (4.56) -> output_z=64'h40123D70A3D70A3D, output_z_stb one cycle after B handshake.
REQ-032 A=64'h40E7FF26B851EB85 (49145.21), B=64'hC0DBBC53851EB852 (-28401.305) -> MODE=1 gives A, MODE=0 gives B.
REQ-033 A=+0, B=-0 -> MODE=1 gives 64'h0; MODE=0 gives 64'h8000000000000000; A=64'hBFF0000000000000, B=64'hC000000000000000, MODE=1 -> 64'hBFF0000000000000.
REQ-034 MODE=1, A=64'h7FF0000000000001, B=64'h3FF0000000000000 -> 64'h7FF8000000000000 with macro; 64'h7FF0000000000001 without.
REQ-035 output_z_ack low 5 cycles, input_a_stb and input_b_stb held high -> output_z/output_z_stb stable, both acks low; result consumed on first ack edge, input_a_ack high next cycle.
REQ-036 rst pulsed one cycle while in PUT_Z -> output_z_stb=0, output_z=0 after that edge; input_a_ack high one cycle after rst falls; next operand pair computes correctly.
